br_stack_multi: RTL and testbench

Multi-dispatch, multi-resolve branch checkpoint stack. It is the superscalar successor to the single-branch stack. It allocates up to B one-hot branch IDs per cycle in program order, with each allocation capturing a recovery checkpoint (map table, free-list head, ROB tail, PC). It retires up to R correctly-predicted branches per cycle and services at most one mispredict squash per cycle. It sits between dispatch and the map table, free list and ROB.

---
 rtl/br_stack_multi_pkg.sv | 34 +++
 rtl/br_stack_multi_psel_gen.sv | 22 ++
 rtl/br_stack_multi.sv | 150 +++++++++++++++
 tb/tb_br_stack_multi.sv | 543 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/br_stack_multi_pkg.sv
// br_stack_multi_pkg: shared types for the multi-dispatch branch checkpoint stack.
// Checkpoint, map-table and CDB bundle layouts plus sizing constants.
package br_stack_multi_pkg;

   localparam int BRANCH_PRED_SZ = 4;
   localparam int N_CDB          = 2;
   localparam int ARCH_REGS      = 8;
   localparam int AREG_W         = $clog2(ARCH_REGS);
   localparam int PREG_W         = 6;
   localparam int FL_W           = 5;
   localparam int ROB_W          = 5;

   typedef struct packed {
      logic [PREG_W-1:0] reg_idx;
      logic              ready;
   } map_table_packet_t;

   typedef struct packed {
      logic                                 valid;
      logic [BRANCH_PRED_SZ-1:0]            b_id;
      logic [BRANCH_PRED_SZ-1:0]            b_mask;
      map_table_packet_t [ARCH_REGS-1:0]    rec_mt;
      logic [FL_W-1:0]                      fl_head;
      logic [ROB_W-1:0]                     rob_tail;
      logic [31:0]                          pc;
   } checkpoint_t;

   typedef struct packed {
      logic              valid;
      logic [AREG_W-1:0] reg_idx;
      logic [PREG_W-1:0] p_reg_idx;
   } cdb_packet_t;

endpackage

// File: rtl/br_stack_multi_psel_gen.sv
// psel_gen: multi-grant lowest-index-first selector.
// Grant i is the i-th lowest set bit of req, or zero if fewer bits remain.
module psel_gen #(
   parameter int WIDTH = 4,
   parameter int REQS  = 2
) (
   input  logic [WIDTH-1:0]            req,
   output logic [REQS-1:0][WIDTH-1:0]  gnt
);

   // peel off the lowest remaining request bit once per grant slot
   always_comb begin
      logic [WIDTH-1:0] rem;
      rem = req;
      gnt = '0;
      for (int i = 0; i < REQS; i++) begin
         gnt[i] = rem & (~rem + WIDTH'(1));
         rem    = rem & ~gnt[i];
      end
   end

endmodule

// File: rtl/br_stack_multi.sv
// br_stack_multi: superscalar branch checkpoint stack.
// Allocates up to B one-hot branch IDs per cycle, retires up to R, squashes one.
module br_stack_multi
   import br_stack_multi_pkg::*;
#(
   parameter int DEPTH = BRANCH_PRED_SZ,
   parameter int N     = N_CDB,
   parameter int B     = 2,
   parameter int R     = 2
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [B-1:0]                  dis_br,
   input  checkpoint_t [B-1:0]           dis_cp,
   input  cdb_packet_t [N-1:0]           cdb_in,
   input  logic                          sq_valid,
   input  logic [DEPTH-1:0]              sq_b_id,
   input  logic [R-1:0]                  clr_valid,
   input  logic [R-1:0][DEPTH-1:0]       clr_b_id,
   output logic [B-1:0][DEPTH-1:0]       assigned_b_id,
   output logic                          dis_stall,
   output checkpoint_t                   cp_out,
   output logic                          cp_valid,
   output logic [$clog2(DEPTH+1)-1:0]    free_cnt,
   output logic                          full
);

   localparam int CW = $clog2(DEPTH+1);

   checkpoint_t             entries     [DEPTH];
   checkpoint_t             entries_nxt [DEPTH];
   logic [DEPTH-1:0]        free_entries;
   logic [DEPTH-1:0]        free_nxt;
   logic [DEPTH-1:0]        clr_mask;
   logic [DEPTH-1:0]        live;
   logic [DEPTH-1:0]        avail;
   logic [DEPTH-1:0]        kill;
   logic [DEPTH-1:0]        prior;
   logic [B-1:0][DEPTH-1:0] gnt;
   logic                    sq_hit;

   function automatic int popcount(input logic [DEPTH-1:0] v);
      int c;
      c = 0;
      for (int i = 0; i < DEPTH; i++)
         if (v[i]) c++;
      return c;
   endfunction

   function automatic checkpoint_t cdb_fwd(
      input checkpoint_t         c,
      input cdb_packet_t [N-1:0] cdb
   );
      checkpoint_t r;
      r = c;
      for (int n = 0; n < N; n++)
         if (cdb[n].valid &&
             r.rec_mt[cdb[n].reg_idx].reg_idx == cdb[n].p_reg_idx)
            r.rec_mt[cdb[n].reg_idx].ready = 1'b1;
      return r;
   endfunction

   psel_gen #(
      .WIDTH (DEPTH),
      .REQS  (B)
   ) u_psel (
      .req (avail),
      .gnt (gnt)
   );

   // clears, then CDB, then squash or allocation, forming the next state
   always_comb begin
      int nreq;
      clr_mask = '0;
      for (int j = 0; j < R; j++)
         if (clr_valid[j]) clr_mask = clr_mask | clr_b_id[j];
      live  = ~free_entries & ~clr_mask;
      avail = free_entries | clr_mask;

      for (int k = 0; k < DEPTH; k++) begin
         entries_nxt[k] = '0;
         if (live[k]) begin
            entries_nxt[k] = cdb_fwd(entries[k], cdb_in);
            entries_nxt[k].b_mask = entries[k].b_mask & ~clr_mask;
         end
      end

      sq_hit   = sq_valid && !reset && (|(sq_b_id & live));
      cp_valid = sq_hit;
      cp_out   = '0;
      kill     = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (sq_hit && sq_b_id[k]) cp_out = entries_nxt[k];
         if (sq_hit && (sq_b_id[k] || (|(entries_nxt[k].b_mask & sq_b_id))))
            kill[k] = 1'b1;
      end

      nreq = 0;
      for (int i = 0; i < B; i++)
         if (dis_br[i]) nreq++;
      dis_stall = reset || sq_valid || (nreq > popcount(avail));

      free_nxt = ~(live & ~kill);
      for (int k = 0; k < DEPTH; k++)
         if (kill[k]) entries_nxt[k] = '0;

      assigned_b_id = '0;
      prior = live;
      for (int i = 0; i < B; i++) begin
         if (!dis_stall && dis_br[i]) begin
            assigned_b_id[i] = gnt[i];
            for (int k = 0; k < DEPTH; k++) begin
               if (gnt[i][k]) begin
                  entries_nxt[k]        = cdb_fwd(dis_cp[i], cdb_in);
                  entries_nxt[k].valid  = 1'b1;
                  entries_nxt[k].b_id   = gnt[i];
                  entries_nxt[k].b_mask = prior;
                  free_nxt[k]           = 1'b0;
               end
            end
            prior = prior | gnt[i];
         end
      end
   end

   // state register; reset discards every allocation
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) entries[k] <= '0;
         free_entries <= '1;
         free_cnt     <= CW'(DEPTH);
         full         <= 1'b0;
      end else begin
         for (int k = 0; k < DEPTH; k++) entries[k] <= entries_nxt[k];
         free_entries <= free_nxt;
         free_cnt     <= CW'(popcount(free_nxt));
         full         <= (free_nxt == '0);
      end
   end

   // free count matches the free vector; no entry depends on itself
   always_ff @(posedge clock) begin
      if (!reset) begin
         assert (popcount(free_entries) == int'(free_cnt));
         for (int k = 0; k < DEPTH; k++)
            assert (!(entries[k].valid && entries[k].b_mask[k]));
      end
   end

endmodule

// File: tb/tb_br_stack_multi.sv
// tb_br_stack_multi: directed scenarios plus randomised traffic for br_stack_multi.
// Expected values come from a per-branch reference model kept in this bench.
module tb_br_stack_multi;
   import br_stack_multi_pkg::*;

   localparam int DEPTH = BRANCH_PRED_SZ;
   localparam int N     = N_CDB;
   localparam int B     = 2;
   localparam int R     = 2;
   localparam int CW    = $clog2(DEPTH+1);

   logic                    clock;
   logic                    reset;
   logic [B-1:0]            dis_br;
   checkpoint_t [B-1:0]     dis_cp;
   cdb_packet_t [N-1:0]     cdb_in;
   logic                    sq_valid;
   logic [DEPTH-1:0]        sq_b_id;
   logic [R-1:0]            clr_valid;
   logic [R-1:0][DEPTH-1:0] clr_b_id;
   logic [B-1:0][DEPTH-1:0] assigned_b_id;
   logic                    dis_stall;
   checkpoint_t             cp_out;
   logic                    cp_valid;
   logic [CW-1:0]           free_cnt;
   logic                    full;

   int checks = 0;
   int errors = 0;

   br_stack_multi #(.DEPTH(DEPTH), .N(N), .B(B), .R(R)) dut (
      .clock         (clock),
      .reset         (reset),
      .dis_br        (dis_br),
      .dis_cp        (dis_cp),
      .cdb_in        (cdb_in),
      .sq_valid      (sq_valid),
      .sq_b_id       (sq_b_id),
      .clr_valid     (clr_valid),
      .clr_b_id      (clr_b_id),
      .assigned_b_id (assigned_b_id),
      .dis_stall     (dis_stall),
      .cp_out        (cp_out),
      .cp_valid      (cp_valid),
      .free_cnt      (free_cnt),
      .full          (full)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // reference model: one record per branch slot
   bit                      m_valid [DEPTH];
   checkpoint_t             m_cp    [DEPTH];
   bit                      n_valid [DEPTH];
   checkpoint_t             n_cp    [DEPTH];
   logic                    e_stall;
   logic                    e_cp_valid;
   checkpoint_t             e_cp;
   logic [B-1:0][DEPTH-1:0] e_assigned;
   int                      e_free;

   function automatic int idx_of(input logic [DEPTH-1:0] v);
      for (int k = 0; k < DEPTH; k++)
         if (v[k]) return k;
      return -1;
   endfunction

   function automatic checkpoint_t ref_cdb(input checkpoint_t c);
      checkpoint_t x;
      x = c;
      for (int n = 0; n < N; n++) begin
         if (cdb_in[n].valid) begin
            int r;
            r = int'(cdb_in[n].reg_idx);
            if (x.rec_mt[r].reg_idx == cdb_in[n].p_reg_idx)
               x.rec_mt[r].ready = 1'b1;
         end
      end
      return x;
   endfunction

   task automatic model_eval();
      bit cleared [DEPTH];
      int nfree, nreq, sidx, f;
      logic [DEPTH-1:0] owned;
      for (int k = 0; k < DEPTH; k++) cleared[k] = 0;
      for (int j = 0; j < R; j++) begin
         if (clr_valid[j]) begin
            f = idx_of(clr_b_id[j]);
            if (f >= 0) cleared[f] = 1;
         end
      end
      for (int k = 0; k < DEPTH; k++) begin
         n_valid[k] = m_valid[k] && !cleared[k];
         n_cp[k] = '0;
         if (n_valid[k]) begin
            n_cp[k] = ref_cdb(m_cp[k]);
            for (int j = 0; j < R; j++)
               if (clr_valid[j])
                  n_cp[k].b_mask = n_cp[k].b_mask & ~clr_b_id[j];
         end
      end
      sidx = idx_of(sq_b_id);
      e_cp_valid = 1'b0;
      e_cp = '0;
      if (!reset && sq_valid && sidx >= 0 && n_valid[sidx]) begin
         e_cp_valid = 1'b1;
         e_cp = n_cp[sidx];
         for (int k = 0; k < DEPTH; k++) begin
            if (k == sidx || n_cp[k].b_mask[sidx]) begin
               n_valid[k] = 0;
               n_cp[k] = '0;
            end
         end
      end
      nreq = 0;
      for (int i = 0; i < B; i++) if (dis_br[i]) nreq++;
      nfree = 0;
      for (int k = 0; k < DEPTH; k++)
         if (!(m_valid[k] && !cleared[k])) nfree++;
      e_stall = reset || sq_valid || (nreq > nfree);
      e_assigned = '0;
      if (!e_stall) begin
         owned = '0;
         for (int k = 0; k < DEPTH; k++) if (n_valid[k]) owned[k] = 1'b1;
         for (int i = 0; i < nreq; i++) begin
            f = -1;
            for (int k = 0; k < DEPTH; k++)
               if (f < 0 && !n_valid[k]) f = k;
            e_assigned[i] = DEPTH'(1) << f;
            n_cp[f] = ref_cdb(dis_cp[i]);
            n_cp[f].valid = 1'b1;
            n_cp[f].b_id = DEPTH'(1) << f;
            n_cp[f].b_mask = owned;
            owned[f] = 1'b1;
            n_valid[f] = 1;
         end
      end
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) begin
            n_valid[k] = 0;
            n_cp[k] = '0;
         end
      end
      e_free = 0;
      for (int k = 0; k < DEPTH; k++) if (!n_valid[k]) e_free++;
   endtask

   task automatic model_commit();
      for (int k = 0; k < DEPTH; k++) begin
         m_valid[k] = n_valid[k];
         m_cp[k] = n_cp[k];
      end
   endtask

   task automatic tick();
      model_eval();
      @(posedge clock);
      model_commit();
      #1;
   endtask

   task automatic idle();
      reset = 1'b0;
      dis_br = '0;
      dis_cp = '0;
      cdb_in = '0;
      sq_valid = 1'b0;
      sq_b_id = '0;
      clr_valid = '0;
      clr_b_id = '0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   function automatic checkpoint_t mk_cp(input logic [31:0] pc);
      checkpoint_t c;
      c = '0;
      c.pc = pc;
      c.fl_head = pc[FL_W-1:0];
      return c;
   endfunction

   task automatic test_reset();
      idle();
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if (free_cnt !== CW'(DEPTH)) begin
         errors++;
         $display("FAIL reset_free_cnt: got %0d expected %0d", free_cnt, DEPTH);
      end
      checks++;
      if (full !== 1'b0) begin
         errors++;
         $display("FAIL reset_full: got %b expected 0", full);
      end
      reset = 1'b0;
      @(negedge clock);
      checks++;
      if (dis_stall !== 1'b0 || cp_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: stall %b cp_valid %b expected 0 0",
                  dis_stall, cp_valid);
      end
      tick();
   endtask

   task automatic test_alloc_basic();
      do_reset();
      dis_br = 2'b11;
      dis_cp[0] = mk_cp(32'h100);
      dis_cp[1] = mk_cp(32'h200);
      @(negedge clock);
      checks++;
      if (assigned_b_id[0] !== 4'b0001 || assigned_b_id[1] !== 4'b0010 ||
          dis_stall !== 1'b0) begin
         errors++;
         $display("FAIL alloc_two: got %b %b stall %b expected 0001 0010 0",
                  assigned_b_id[0], assigned_b_id[1], dis_stall);
      end
      tick();
      idle();
      checks++;
      if (free_cnt !== CW'(2)) begin
         errors++;
         $display("FAIL alloc_free_cnt: got %0d expected 2", free_cnt);
      end
      sq_valid = 1'b1;
      sq_b_id = 4'b0010;
      @(negedge clock);
      checks++;
      if (cp_valid !== 1'b1 || cp_out.b_mask !== 4'b0001 ||
          cp_out.pc !== 32'h200) begin
         errors++;
         $display("FAIL alloc_mask: valid %b mask %b pc %h expected 1 0001 200",
                  cp_valid, cp_out.b_mask, cp_out.pc);
      end
      tick();
      idle();
      checks++;
      if (free_cnt !== CW'(3)) begin
         errors++;
         $display("FAIL alloc_sq_cnt: got %0d expected 3", free_cnt);
      end
   endtask

   task automatic test_full_stall();
      do_reset();
      dis_br = 2'b11;
      tick();
      dis_br = 2'b11;
      tick();
      idle();
      checks++;
      if (full !== 1'b1 || free_cnt !== CW'(0)) begin
         errors++;
         $display("FAIL full_flag: full %b cnt %0d expected 1 0", full, free_cnt);
      end
      dis_br = 2'b01;
      dis_cp[0] = mk_cp(32'h500);
      @(negedge clock);
      checks++;
      if (dis_stall !== 1'b1 || assigned_b_id !== '0) begin
         errors++;
         $display("FAIL full_stall: stall %b ids %h expected 1 0",
                  dis_stall, assigned_b_id);
      end
      tick();
      checks++;
      if (free_cnt !== CW'(0) || full !== 1'b1) begin
         errors++;
         $display("FAIL full_hold: cnt %0d full %b expected 0 1", free_cnt, full);
      end
      clr_valid = 2'b01;
      clr_b_id[0] = 4'b0001;
      @(negedge clock);
      checks++;
      if (dis_stall !== 1'b0 || assigned_b_id[0] !== 4'b0001) begin
         errors++;
         $display("FAIL full_clr_alloc: stall %b id %b expected 0 0001",
                  dis_stall, assigned_b_id[0]);
      end
      tick();
      idle();
      sq_valid = 1'b1;
      sq_b_id = 4'b0001;
      @(negedge clock);
      checks++;
      if (cp_valid !== 1'b1 || cp_out.b_mask !== 4'b1110 ||
          cp_out.pc !== 32'h500) begin
         errors++;
         $display("FAIL full_clr_mask: valid %b mask %b pc %h expected 1 1110 500",
                  cp_valid, cp_out.b_mask, cp_out.pc);
      end
      tick();
      idle();
      checks++;
      if (free_cnt !== CW'(1)) begin
         errors++;
         $display("FAIL full_sq_cnt: got %0d expected 1", free_cnt);
      end
   endtask

   task automatic test_squash();
      do_reset();
      dis_br = 2'b01;
      dis_cp[0] = mk_cp(32'h10);
      tick();
      dis_cp[0] = mk_cp(32'h20);
      tick();
      dis_cp[0] = mk_cp(32'h30);
      tick();
      idle();
      sq_valid = 1'b1;
      sq_b_id = 4'b0010;
      dis_br = 2'b01;
      dis_cp[0] = mk_cp(32'h40);
      @(negedge clock);
      checks++;
      if (cp_valid !== 1'b1 || cp_out.pc !== 32'h20 ||
          cp_out.b_mask !== 4'b0001) begin
         errors++;
         $display("FAIL squash_cp: valid %b pc %h mask %b expected 1 20 0001",
                  cp_valid, cp_out.pc, cp_out.b_mask);
      end
      checks++;
      if (dis_stall !== 1'b1 || assigned_b_id !== '0) begin
         errors++;
         $display("FAIL squash_drop: stall %b ids %h expected 1 0",
                  dis_stall, assigned_b_id);
      end
      tick();
      idle();
      checks++;
      if (free_cnt !== CW'(3)) begin
         errors++;
         $display("FAIL squash_cnt: got %0d expected 3", free_cnt);
      end
   endtask

   task automatic test_double_clear();
      do_reset();
      dis_br = 2'b11;
      tick();
      dis_br = 2'b01;
      dis_cp[0] = mk_cp(32'h77);
      tick();
      idle();
      clr_valid = 2'b11;
      clr_b_id[0] = 4'b0001;
      clr_b_id[1] = 4'b0010;
      tick();
      idle();
      checks++;
      if (free_cnt !== CW'(3)) begin
         errors++;
         $display("FAIL dclr_cnt: got %0d expected 3", free_cnt);
      end
      sq_valid = 1'b1;
      sq_b_id = 4'b0100;
      @(negedge clock);
      checks++;
      if (cp_valid !== 1'b1 || cp_out.b_mask !== 4'b0000 ||
          cp_out.pc !== 32'h77) begin
         errors++;
         $display("FAIL dclr_mask: valid %b mask %b pc %h expected 1 0000 77",
                  cp_valid, cp_out.b_mask, cp_out.pc);
      end
      tick();
      idle();
   endtask

   task automatic test_cdb_forward();
      do_reset();
      dis_br = 2'b01;
      dis_cp[0] = mk_cp(32'h99);
      dis_cp[0].rec_mt[5].reg_idx = PREG_W'(12);
      dis_cp[0].rec_mt[5].ready = 1'b0;
      dis_cp[0].rec_mt[3].reg_idx = PREG_W'(7);
      cdb_in[0].valid = 1'b1;
      cdb_in[0].reg_idx = AREG_W'(5);
      cdb_in[0].p_reg_idx = PREG_W'(12);
      tick();
      idle();
      sq_valid = 1'b1;
      sq_b_id = 4'b0001;
      @(negedge clock);
      checks++;
      if (cp_valid !== 1'b1 || cp_out.rec_mt[5].ready !== 1'b1 ||
          cp_out.rec_mt[5].reg_idx !== PREG_W'(12) ||
          cp_out.rec_mt[3].ready !== 1'b0) begin
         errors++;
         $display("FAIL cdb_fwd: valid %b r5 %0d/%b r3 %b expected 1 12/1 0",
                  cp_valid, cp_out.rec_mt[5].reg_idx,
                  cp_out.rec_mt[5].ready, cp_out.rec_mt[3].ready);
      end
      tick();
      idle();
      sq_valid = 1'b1;
      sq_b_id = 4'b1000;
      @(negedge clock);
      checks++;
      if (cp_valid !== 1'b0) begin
         errors++;
         $display("FAIL bad_squash: cp_valid %b expected 0", cp_valid);
      end
      tick();
      idle();
   endtask

   task automatic test_reset_mid();
      do_reset();
      dis_br = 2'b11;
      tick();
      dis_br = 2'b01;
      tick();
      idle();
      checks++;
      if (free_cnt !== CW'(1)) begin
         errors++;
         $display("FAIL rmid_pre: got %0d expected 1", free_cnt);
      end
      reset = 1'b1;
      sq_valid = 1'b1;
      sq_b_id = 4'b0001;
      dis_br = 2'b01;
      tick();
      reset = 1'b0;
      dis_br = '0;
      checks++;
      if (free_cnt !== CW'(DEPTH) || full !== 1'b0) begin
         errors++;
         $display("FAIL rmid_state: cnt %0d full %b expected %0d 0",
                  free_cnt, full, DEPTH);
      end
      @(negedge clock);
      checks++;
      if (cp_valid !== 1'b0) begin
         errors++;
         $display("FAIL rmid_cp: cp_valid %b expected 0", cp_valid);
      end
      tick();
      idle();
   endtask

   function automatic int pick_idx();
      int cand[$];
      for (int k = 0; k < DEPTH; k++) if (m_valid[k]) cand.push_back(k);
      if (cand.size() > 0 && $urandom_range(0, 3) != 0)
         return cand[$urandom_range(0, cand.size() - 1)];
      return int'($urandom_range(0, DEPTH - 1));
   endfunction

   function automatic checkpoint_t rand_cp();
      checkpoint_t c;
      c.valid = 1'($urandom_range(0, 1));
      c.b_id = DEPTH'($urandom);
      c.b_mask = DEPTH'($urandom);
      for (int r = 0; r < ARCH_REGS; r++) begin
         c.rec_mt[r].reg_idx = PREG_W'($urandom_range(0, 15));
         c.rec_mt[r].ready = 1'($urandom_range(0, 1));
      end
      c.fl_head = FL_W'($urandom);
      c.rob_tail = ROB_W'($urandom);
      c.pc = $urandom;
      return c;
   endfunction

   task automatic rand_inputs();
      int nreq;
      reset = ($urandom_range(0, 99) == 0);
      nreq = int'($urandom_range(0, B));
      dis_br = '0;
      for (int i = 0; i < nreq; i++) dis_br[i] = 1'b1;
      for (int i = 0; i < B; i++) dis_cp[i] = rand_cp();
      for (int n = 0; n < N; n++) begin
         cdb_in[n].valid = 1'($urandom_range(0, 1));
         cdb_in[n].reg_idx = AREG_W'($urandom_range(0, ARCH_REGS - 1));
         cdb_in[n].p_reg_idx = PREG_W'($urandom_range(0, 15));
      end
      sq_valid = ($urandom_range(0, 7) == 0);
      sq_b_id = DEPTH'(1) << pick_idx();
      for (int j = 0; j < R; j++) begin
         clr_valid[j] = ($urandom_range(0, 3) == 0);
         clr_b_id[j] = DEPTH'(1) << pick_idx();
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         rand_inputs();
         @(negedge clock);
         model_eval();
         checks++;
         if (dis_stall !== e_stall || assigned_b_id !== e_assigned) begin
            errors++;
            $display("FAIL rnd_alloc cyc %0d: stall %b ids %h expected %b %h",
                     c, dis_stall, assigned_b_id, e_stall, e_assigned);
         end
         checks++;
         if (cp_valid !== e_cp_valid || cp_out !== e_cp) begin
            errors++;
            $display("FAIL rnd_cp cyc %0d: valid %b pc %h mask %b expected %b %h %b",
                     c, cp_valid, cp_out.pc, cp_out.b_mask,
                     e_cp_valid, e_cp.pc, e_cp.b_mask);
         end
         tick();
         checks++;
         if (free_cnt !== CW'(e_free) || full !== (e_free == 0)) begin
            errors++;
            $display("FAIL rnd_cnt cyc %0d: cnt %0d full %b expected %0d %b",
                     c, free_cnt, full, e_free, e_free == 0);
         end
      end
      idle();
   endtask

   initial begin
      idle();
      test_reset();
      test_alloc_basic();
      test_full_stall();
      test_squash();
      test_double_clear();
      test_cdb_forward();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
